// File: rtl/loa_lane_accumulator_if.sv
// Bundles the packed-word input and the valid/ready result output of the
// LOA lane accumulator. The master side is the producer/consumer pair
// around the block; the slave side is the accumulator itself.
interface loa_lane_accumulator_if #(
  parameter int DIN_WIDTH  = 8,
  parameter int LANES_LOG2 = 2,
  parameter int ACC_WIDTH  = 12
);
  logic                                  din_valid;
  logic [DIN_WIDTH*(1<<LANES_LOG2)-1:0]  din;
  logic                                  sum_valid;
  logic                                  sum_ready;
  logic [ACC_WIDTH-1:0]                  sum;
  logic                                  ovf;

  modport master (
    output din_valid, din, sum_ready,
    input  sum_valid, sum, ovf
  );

  modport slave (
    input  din_valid, din, sum_ready,
    output sum_valid, sum, ovf
  );
endinterface

// File: rtl/loa_lane_accumulator.sv
// loa_lane_accumulator
// Reduces the four lanes of each packed word through a two-level pipelined
// lower-part-OR (LOA) adder tree, accumulates 2**ACC_LOG2 reduced words and
// presents the total through a one-entry valid/ready holding register.
// The input is never stalled; a result overwritten before it is accepted
// sets the sticky ovf flag.
// Optional build macro: EXACT_TREE_EN -- replaces every tree adder with an
// exact adder (golden baseline); latency and handshake are unchanged.
module loa_lane_accumulator #(
  parameter int DIN_WIDTH   = 8,
  parameter int LANES_LOG2  = 2,
  parameter int APPROX_BITS = 3,
  parameter int ACC_LOG2    = 2,
  parameter int ACC_WIDTH   = DIN_WIDTH + LANES_LOG2 + ACC_LOG2
) (
  input  logic                   clk,
  input  logic                   rst,   // asynchronous, active low
  loa_lane_accumulator_if.slave  bus
);

  localparam int LANES = 1 << LANES_LOG2;
  localparam int S1_W  = DIN_WIDTH + 1;
  localparam int S2_W  = DIN_WIDTH + 2;
  localparam logic [ACC_LOG2-1:0] CNT_MAX = '1;

  // Level-1 adder: two lanes in, one bit wider out.
  function automatic logic [S1_W-1:0] add_l1(input logic [DIN_WIDTH-1:0] a,
                                             input logic [DIN_WIDTH-1:0] b);
    logic [DIN_WIDTH-APPROX_BITS:0] upper;
`ifdef EXACT_TREE_EN
    upper  = '0;
    add_l1 = {1'b0, a} + {1'b0, b} + {{(S1_W-1){1'b0}}, upper[0]};
`else
    // Upper part is exact; its carry-in is guessed from the top OR'd bit pair.
    upper  = {1'b0, a[DIN_WIDTH-1:APPROX_BITS]} + {1'b0, b[DIN_WIDTH-1:APPROX_BITS]}
           + {{(DIN_WIDTH-APPROX_BITS){1'b0}}, a[APPROX_BITS-1] & b[APPROX_BITS-1]};
    add_l1 = {upper, a[APPROX_BITS-1:0] | b[APPROX_BITS-1:0]};
`endif
  endfunction

  // Level-2 adder: two level-1 results in, one bit wider out.
  function automatic logic [S2_W-1:0] add_l2(input logic [S1_W-1:0] a,
                                             input logic [S1_W-1:0] b);
    logic [S1_W-APPROX_BITS:0] upper;
`ifdef EXACT_TREE_EN
    upper  = '0;
    add_l2 = {1'b0, a} + {1'b0, b} + {{(S2_W-1){1'b0}}, upper[0]};
`else
    upper  = {1'b0, a[S1_W-1:APPROX_BITS]} + {1'b0, b[S1_W-1:APPROX_BITS]}
           + {{(S1_W-APPROX_BITS){1'b0}}, a[APPROX_BITS-1] & b[APPROX_BITS-1]};
    add_l2 = {upper, a[APPROX_BITS-1:0] | b[APPROX_BITS-1:0]};
`endif
  endfunction

  logic [DIN_WIDTH-1:0] w_lane [LANES];
  logic [S1_W-1:0]      w_s1   [LANES/2];
  logic [S1_W-1:0]      r_s1   [LANES/2];
  logic                 r_v1;
  logic [S2_W-1:0]      r_s2;
  logic                 r_v2;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_LOG2-1:0]  r_cnt;
  logic [ACC_WIDTH-1:0] r_sum;
  logic                 r_sum_valid;
  logic                 r_ovf;

  logic [ACC_WIDTH-1:0] w_s2_ext;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic                 w_new_result;
  logic                 w_xfer;

  // Lane i sits at bits [DIN_WIDTH*i +: DIN_WIDTH]; lane 0 arrived first.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign w_lane[gi] = bus.din[DIN_WIDTH*gi +: DIN_WIDTH];
    end

    for (gi = 0; gi < LANES/2; gi++) begin : g_stage1
      assign w_s1[gi] = add_l1(w_lane[2*gi], w_lane[2*gi+1]);

      // Stage 1: register one adjacent-lane pair sum per accepted word.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_s1[gi] <= '0;
        end else if (bus.din_valid) begin
          r_s1[gi] <= w_s1[gi];
        end
      end
    end
  endgenerate

  // Stage 1/2 valid pipeline; runs every cycle, never stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= bus.din_valid;
      r_v2 <= r_v1;
    end
  end

  // Stage 2: combine the two pair sums into one reduced word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2 <= '0;
    end else if (r_v1) begin
      r_s2 <= add_l2(r_s1[0], r_s1[1]);
    end
  end

  assign w_s2_ext     = {{(ACC_WIDTH-S2_W){1'b0}}, r_s2};
  assign w_acc_next   = r_acc + w_s2_ext;
  assign w_new_result = r_v2 && (r_cnt == CNT_MAX);
  assign w_xfer       = r_sum_valid && bus.sum_ready;

  // Stage 3: exact accumulation; the last word of a group clears the accumulator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_v2) begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_new_result ? '0 : w_acc_next;
    end
  end

  // Holding register: new result wins; overwriting an unaccepted one flags ovf.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_new_result) begin
      r_sum       <= w_acc_next;
      r_sum_valid <= 1'b1;
      if (r_sum_valid && !bus.sum_ready) begin
        r_ovf <= 1'b1;
      end
    end else if (w_xfer) begin
      r_sum_valid <= 1'b0;
    end
  end

  assign bus.sum       = r_sum;
  assign bus.sum_valid = r_sum_valid;
  assign bus.ovf       = r_ovf;

endmodule
